// File: rtl/sat_block_accum_if.sv
// Handshake bundle for sat_block_accum: narrow sample input, block result output.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready; the source
// holds valid and its payload until that edge, ready never waits on valid.
interface sat_block_accum_if #(
  parameter int IN_WIDTH  = 4,
  parameter int ACC_WIDTH = 8,
  parameter int BLOCK_LEN = 4
);
  localparam int CW = $clog2(BLOCK_LEN + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_sum;
  logic [CW-1:0]               out_clip_cnt;
  logic                        out_ovf;
  logic                        dbg_full;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_clip_cnt, out_ovf, dbg_full
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_clip_cnt, out_ovf, dbg_full
  );
endinterface

// File: rtl/sat_block_accum.sv
// Block-wise saturating accumulator for narrow signed samples; each block yields a
// saturated sum, a count of clipped input codes and a sticky overflow flag.
module sat_block_accum #(
  parameter int IN_WIDTH  = 4,
  parameter int ACC_WIDTH = 8,
  parameter int BLOCK_LEN = 4
) (
  input logic          clk,
  input logic          rst_b,
  sat_block_accum_if.slave bus
);
  localparam int CW = $clog2(BLOCK_LEN + 1);
  localparam int IW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_LEN - 1);
  localparam logic signed [ACC_WIDTH:0] ACC_MAX = (ACC_WIDTH+1)'((1 <<< (ACC_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = (ACC_WIDTH+1)'(-(1 <<< (ACC_WIDTH-1)));
  localparam logic signed [IN_WIDTH-1:0] IN_MAX = IN_WIDTH'((1 <<< (IN_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] IN_MIN = IN_WIDTH'(-(1 <<< (IN_WIDTH-1)));

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               clip_q, clip_d;
  logic [CW-1:0]               oclip_q, oclip_d;
  logic                        ovf_q, ovf_d;
  logic                        oovf_q, oovf_d;

  logic signed [ACC_WIDTH:0]   s_wide;
  logic signed [ACC_WIDTH-1:0] acc_sat;
  logic [CW-1:0]               clip_next;
  logic                        sat_hit, is_clip, is_last;
  logic                        in_ready, in_fire, out_fire;

  assign is_last  = (idx_q == IDX_LAST);
  // Only the block-closing sample needs a free output slot; all others flow freely.
  assign in_ready = (state_q == EMPTY) || !is_last || bus.out_ready;
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = (state_q == FULL) && bus.out_ready;

  always_comb begin
    s_wide = {acc_q[ACC_WIDTH-1], acc_q}
           + {{(ACC_WIDTH+1-IN_WIDTH){bus.in_data[IN_WIDTH-1]}}, bus.in_data};
    sat_hit = 1'b0;
    acc_sat = s_wide[ACC_WIDTH-1:0];
    if (s_wide > ACC_MAX) begin
      acc_sat = ACC_MAX[ACC_WIDTH-1:0];
      sat_hit = 1'b1;
    end else if (s_wide < ACC_MIN) begin
      acc_sat = ACC_MIN[ACC_WIDTH-1:0];
      sat_hit = 1'b1;
    end
    is_clip   = (bus.in_data == IN_MAX) || (bus.in_data == IN_MIN);
    clip_next = clip_q + CW'(is_clip);

    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    clip_d  = clip_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    oclip_d = oclip_q;
    oovf_d  = oovf_q;

    if (out_fire) state_d = EMPTY;

    // A closing sample in FULL implies out_fire this cycle, so the reload wins.
    if (in_fire) begin
      if (is_last) begin
        sum_d   = acc_sat;
        oclip_d = clip_next;
        oovf_d  = ovf_q | sat_hit;
        state_d = FULL;
        acc_d   = '0;
        idx_d   = '0;
        clip_d  = '0;
        ovf_d   = 1'b0;
      end else begin
        acc_d  = acc_sat;
        idx_d  = idx_q + IW'(1);
        clip_d = clip_next;
        ovf_d  = ovf_q | sat_hit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      idx_q   <= '0;
      clip_q  <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      oclip_q <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      clip_q  <= clip_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      oclip_q <= oclip_d;
      oovf_q  <= oovf_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state_q == FULL);
  assign bus.out_sum      = sum_q;
  assign bus.out_clip_cnt = oclip_q;
  assign bus.out_ovf      = oovf_q;
  assign bus.dbg_full     = (state_q == FULL);
endmodule

// File: tb/tb_sat_block_accum.sv
// Bench for sat_block_accum: directed block table on 8- and 5-bit accumulators,
// backpressure and reset sequences, then random streams for BLOCK_LEN 1 and 5.
module tb_sat_block_accum;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;
  logic start_rand = 1'b0;

  always #5 clk = ~clk;

  sat_block_accum_if #(.IN_WIDTH(4), .ACC_WIDTH(8), .BLOCK_LEN(4)) if_a ();
  sat_block_accum_if #(.IN_WIDTH(4), .ACC_WIDTH(5), .BLOCK_LEN(4)) if_b ();

  sat_block_accum #(.IN_WIDTH(4), .ACC_WIDTH(8), .BLOCK_LEN(4)) dut_a (
    .clk(clk), .rst_b(rst_b), .bus(if_a));
  sat_block_accum #(.IN_WIDTH(4), .ACC_WIDTH(5), .BLOCK_LEN(4)) dut_b (
    .clk(clk), .rst_b(rst_b), .bus(if_b));

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic mark_done();
    done_cnt++;
  endtask

  task automatic set_in(input int sel, input bit v, input int d, input bit rdy);
    if (sel == 0) begin
      if_a.in_valid = v; if_a.in_data = 4'(d); if_a.out_ready = rdy;
    end else begin
      if_b.in_valid = v; if_b.in_data = 4'(d); if_b.out_ready = rdy;
    end
  endtask

  function automatic int rd_ready(input int sel);
    return (sel == 0) ? int'(if_a.in_ready) : int'(if_b.in_ready);
  endfunction
  function automatic int rd_valid(input int sel);
    return (sel == 0) ? int'(if_a.out_valid) : int'(if_b.out_valid);
  endfunction
  function automatic int rd_sum(input int sel);
    return (sel == 0) ? int'($signed(if_a.out_sum)) : int'($signed(if_b.out_sum));
  endfunction
  function automatic int rd_clip(input int sel);
    return (sel == 0) ? int'(if_a.out_clip_cnt) : int'(if_b.out_clip_cnt);
  endfunction
  function automatic int rd_ovf(input int sel);
    return (sel == 0) ? int'(if_a.out_ovf) : int'(if_b.out_ovf);
  endfunction

  typedef struct {
    int sel;
    int s0, s1, s2, s3;
    int e_sum, e_clip, e_ovf;
  } vec_t;

  // Feeds one block back-to-back with out_ready high and checks the one-cycle result.
  task automatic apply_block(input vec_t v, input string tag);
    int s[4];
    s[0] = v.s0; s[1] = v.s1; s[2] = v.s2; s[3] = v.s3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_in(v.sel, 1'b1, s[i], 1'b1);
      @(negedge clk);
      check({tag, " in_ready"}, rd_ready(v.sel), 1);
    end
    @(posedge clk); #1;
    set_in(v.sel, 1'b0, 0, 1'b1);
    @(negedge clk);
    check({tag, " out_valid"}, rd_valid(v.sel), 1);
    check({tag, " out_sum"}, rd_sum(v.sel), v.e_sum);
    check({tag, " out_clip_cnt"}, rd_clip(v.sel), v.e_clip);
    check({tag, " out_ovf"}, rd_ovf(v.sel), v.e_ovf);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " out_valid drop"}, rd_valid(v.sel), 0);
  endtask

  // Random streams against a step-wise saturating model, BLOCK_LEN 1 and 5.
  for (genvar g = 0; g < 2; g++) begin : g_rand
    localparam int BL = (g == 0) ? 1 : 5;
    sat_block_accum_if #(.IN_WIDTH(4), .ACC_WIDTH(8), .BLOCK_LEN(BL)) rif ();
    sat_block_accum #(.IN_WIDTH(4), .ACC_WIDTH(8), .BLOCK_LEN(BL)) rdut (
      .clk(clk), .rst_b(rst_b), .bus(rif));

    initial begin
      logic [12:0] exp_q[$];
      logic [12:0] held, got;
      bit   hold_pending, in_fire, out_fire, pending;
      int   macc, mclip, mcnt, n_acc, n_out, sd, cyc, r;
      logic movf;
      logic [3:0] nd;
      rif.in_valid = 1'b0; rif.in_data = '0; rif.out_ready = 1'b0;
      macc = 0; mclip = 0; mcnt = 0; movf = 1'b0; n_acc = 0; n_out = 0;
      hold_pending = 1'b0; pending = 1'b0; held = '0; cyc = 0;
      wait (start_rand);
      while (cyc < 20000) begin
        cyc++;
        @(posedge clk); #1;
        if (!pending) begin
          rif.in_valid = (n_acc < 1000) && ($urandom_range(0, 99) < 70);
          r = $urandom_range(0, 3);
          nd = (r == 0) ? 4'd7 : (r == 1) ? 4'b1000 : 4'($urandom_range(0, 15));
          rif.in_data = nd;
        end
        rif.out_ready = (n_acc >= 1000) || ($urandom_range(0, 99) < 60);
        @(negedge clk);
        in_fire  = rif.in_valid && rif.in_ready;
        out_fire = rif.out_valid && rif.out_ready;
        got = {rif.out_ovf, 4'(rif.out_clip_cnt), rif.out_sum};
        if (hold_pending) begin
          check("rand held out_valid", int'(rif.out_valid), 1);
          check("rand held payload", int'(got), int'(held));
        end
        if (!rif.out_valid || rif.out_ready)
          check("rand in_ready free", int'(rif.in_ready), 1);
        if (out_fire) begin
          n_out++;
          if (exp_q.size() == 0) check("rand unexpected result", int'(got), -1);
          else check("rand result", int'(got), int'(exp_q.pop_front()));
        end
        if (in_fire) begin
          n_acc++;
          sd = int'($signed(rif.in_data));
          macc = macc + sd;
          if (macc > 127) begin macc = 127; movf = 1'b1; end
          else if (macc < -128) begin macc = -128; movf = 1'b1; end
          if (sd == 7 || sd == -8) mclip++;
          mcnt++;
          if (mcnt == BL) begin
            exp_q.push_back({movf, 4'(mclip), 8'(macc)});
            macc = 0; mclip = 0; mcnt = 0; movf = 1'b0;
          end
        end
        pending = rif.in_valid && !in_fire;
        hold_pending = rif.out_valid && !rif.out_ready;
        held = got;
        if (n_acc == 1000 && exp_q.size() == 0 && !rif.out_valid) break;
      end
      check("rand samples accepted", n_acc, 1000);
      check("rand results emitted", n_out, 1000 / BL);
      check("rand queue drained", exp_q.size(), 0);
      rif.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rand no extra result", int'(rif.out_valid), 0);
      mark_done();
    end
  end

  initial begin
    vec_t tbl[8];
    int   n;
    tbl[0] = '{0, 1, 2, 3, -4, 2, 0, 0};
    tbl[1] = '{0, 7, 7, -8, -8, -2, 4, 0};
    tbl[2] = '{0, -8, -8, -8, -8, -32, 4, 0};
    tbl[3] = '{0, 7, -1, 0, 7, 13, 2, 0};
    tbl[4] = '{1, 7, 7, 7, -8, 7, 4, 1};
    tbl[5] = '{1, 1, 1, 1, 1, 4, 0, 0};
    tbl[6] = '{1, -8, -8, -8, 7, -9, 4, 1};
    tbl[7] = '{1, -8, -8, 7, 7, -2, 4, 0};

    set_in(0, 1'b0, 0, 1'b0);
    set_in(1, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("reset out_valid", rd_valid(0), 0);
    check("reset out_sum", rd_sum(0), 0);
    check("reset out_clip_cnt", rd_clip(0), 0);
    check("reset out_ovf", rd_ovf(0), 0);
    check("reset in_ready", rd_ready(0), 1);
    check("reset state", int'(if_a.dbg_full), 0);

    for (int i = 0; i < 8; i++) apply_block(tbl[i], $sformatf("blk%0d", i));

    // Backpressure: block of 1s left pending, then a stream of 2s.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      set_in(0, 1'b1, 1, 1'b0);
      @(negedge clk);
      check("bp fill in_ready", rd_ready(0), 1);
    end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_in(0, 1'b1, 2, 1'b0);
      @(negedge clk);
      if (rd_ready(0) == 1) n++;
      check("bp out_valid held", rd_valid(0), 1);
      check("bp out_sum held", rd_sum(0), 4);
    end
    check("bp accepted count", n, 3);
    check("bp stalled in_ready", rd_ready(0), 0);
    @(posedge clk); #1;
    set_in(0, 1'b1, 2, 1'b1);
    @(negedge clk);
    check("bp release in_ready", rd_ready(0), 1);
    check("bp release out_sum", rd_sum(0), 4);
    @(posedge clk); #1;
    set_in(0, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("bp reload out_valid", rd_valid(0), 1);
    check("bp reload out_sum", rd_sum(0), 8);
    check("bp reload out_clip_cnt", rd_clip(0), 0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 0, 1'b1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("bp drained out_valid", rd_valid(0), 0);

    // Reset with a pending result and a partial block of 3s.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      set_in(0, 1'b1, (i < 4) ? 1 : 3, 1'b0);
      @(negedge clk);
      check("rst fill in_ready", rd_ready(0), 1);
    end
    @(posedge clk); #1;
    set_in(0, 1'b0, 0, 1'b0);
    check("rst pending out_sum", rd_sum(0), 4);
    #2 rst_b = 1'b0;
    #1;
    check("rst async out_valid", rd_valid(0), 0);
    check("rst async out_sum", rd_sum(0), 0);
    check("rst async state", int'(if_a.dbg_full), 0);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    apply_block('{0, 1, 1, 1, 1, 4, 0, 0}, "post-rst");

    start_rand = 1'b1;
    n = 0;
    while (done_cnt < 2 && n < 45000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < 2) check("rand completion", done_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sat_block_accum.md
# sat_block_accum

- Receive-side consumer for streams produced by the signed saturating narrower (8-bit to 4-bit clamp).
- Accepts narrow signed samples over a valid/ready handshake and sums each block of BLOCK_LEN samples in a saturating accumulator.
- Counts clipped codes (samples at the narrow format's max or min) per block.
- Presents the block sum, clip count and overflow flag on a registered valid/ready output.

## Interface

Parameters:
- IN_WIDTH, 4, signed input sample width.
- ACC_WIDTH, 8, signed accumulator/output width; must be >= IN_WIDTH.
- BLOCK_LEN, 4, samples per block; must be >= 1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_b  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  IN_WIDTH  signed sample.
- out_valid  output  1  block result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  ACC_WIDTH  signed saturated block sum.
- out_clip_cnt  output  $clog2(BLOCK_LEN+1)  number of clipped samples in the block.
- out_ovf  output  1  accumulator saturated at least once during the block.

## Operation

Transfers:
- An input transfer occurs when in_valid && in_ready.
- An output transfer occurs when out_valid && out_ready.

Internal state:
- acc: signed, ACC_WIDTH bits.
- idx: 0..BLOCK_LEN-1.
- clip_cnt.
- ovf_sticky.

Per accepted sample:
- Compute s = sext(acc, ACC_WIDTH+1) + sext(in_data, ACC_WIDTH+1).
- Clamp s to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and write the result to acc.
- Saturation is applied per step, so the result is order-dependent.
- If s was clamped, set ovf_sticky.
- If in_data == 2^(IN_WIDTH-1)-1 or in_data == -2^(IN_WIDTH-1), increment clip_cnt.

Last sample of a block (idx == BLOCK_LEN-1 when accepted):
- Load out_sum, out_clip_cnt and out_ovf with the values that include this sample.
- Set out_valid.
- Clear acc, clip_cnt, ovf_sticky and idx to 0.

Otherwise, an accepted sample increments idx.

Output state machine:
- EMPTY (out_valid=0):
  - in_ready=1.
  - Accepting the last sample of a block moves to FULL.
- FULL (out_valid=1):
  - out_sum, out_clip_cnt and out_ovf are held stable until the output transfer.
  - Accumulation of the next block continues in parallel.
  - in_ready = (idx != BLOCK_LEN-1) || out_ready.
  - Output transfer with no new last sample: go to EMPTY.
  - Output transfer in the same cycle a new last sample is accepted: output registers reload with the new block and the state stays FULL.

Other rules:
- in_ready never depends on in_valid.
- out_valid never depends on out_ready.
- BLOCK_LEN=1: every accepted sample is its own block; out_sum = sat(sext(in_data)).

## Timing

- Reset (rst_b low, asynchronous): out_valid=0, out_sum=0, out_clip_cnt=0, out_ovf=0, acc=0, idx=0, clip_cnt=0, ovf_sticky=0, state EMPTY.
  - in_ready=1 from the first cycle after reset release.
- Reset mid-block or with a pending output: the partial block and the pending result are discarded; nothing is emitted.
- Latency: out_valid rises on the clock edge that accepts the last sample, so it is visible in the next cycle.
- Throughput:
  - One sample per cycle while out_ready is high or out_valid is low.
  - No bubble between blocks.
- Backpressure: stall occurs only on the last sample of a block while the previous result is still unconsumed.
- Sustained input with out_ready held low:
  - Exactly BLOCK_LEN-1 further samples are accepted.
  - in_ready then drops until out_ready.

## Test plan

Unless stated otherwise, defaults are used (IN_WIDTH=4, ACC_WIDTH=8, BLOCK_LEN=4).

- Post-reset checks: all outputs are 0 and in_ready=1. Feed samples 1,2,3,-4 in consecutive cycles with out_ready=1.
  - Required response: out_valid for exactly 1 cycle, one cycle after -4 is accepted.
  - out_sum=2, out_clip_cnt=0, out_ovf=0.
- Clipped codes: feed 7,7,-8,-8.
  - Required response: out_sum=-2, out_clip_cnt=4, out_ovf=0.
- Accumulator overflow with ACC_WIDTH=5: feed 7,7,7,-8.
  - Running sums: 7, 14, 15 (clamped), 7.
  - Required response: out_sum=7, out_ovf=1, out_clip_cnt=4.
  - Next block 1,1,1,1: out_ovf=0, out_sum=4.
- Backpressure: hold out_ready=0 after block 1 (1,1,1,1) completes and keep in_valid=1 with samples 2,2,2,2.
  - Exactly 3 samples are accepted, then in_ready=0.
  - out_sum stays 4 throughout.
  - Raising out_ready for one cycle transfers sum 4 and accepts the 4th sample in the same cycle.
  - Next cycle: out_sum=8, out_valid=1.
- Reset mid-block: after accepting 3,3, pulse rst_b low asynchronously (between edges).
  - Outputs clear immediately.
  - Then feed 1,1,1,1: out_sum=4, with no residue from the 3s.
- Random stream: random in_valid/out_ready, 1000 samples with BLOCK_LEN=1 and BLOCK_LEN=5.
  - Compare against a reference model of step-wise saturating accumulation.
  - No sample is lost or duplicated.
  - Outputs stay stable while out_valid && !out_ready.
